// File: rtl/uart_seq_pkg.sv
// Shared definitions for the ISO7816 UART exchange sequencer: state encoding,
// error codes and bit positions inside the UART interface status byte.
package uart_seq_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        FLUSH       = 4'd1,
        TX_LOAD     = 4'd2,
        TX_WRITE    = 4'd3,
        TX_WAIT_SET = 4'd4,
        TX_WAIT_CLR = 4'd5,
        TX_DRAIN    = 4'd6,
        RX_WAIT     = 4'd7,
        RX_HOLD     = 4'd8,
        RX_ACK      = 4'd9,
        DONE        = 4'd10
    } seqState_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_FRAME   = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam int unsigned TXRUN      = 7;
    localparam int unsigned TXPENDING  = 6;
    localparam int unsigned RXRUN      = 5;
    localparam int unsigned RXSTARTBIT = 4;
    localparam int unsigned ISTX       = 3;
    localparam int unsigned OVERRUN    = 2;
    localparam int unsigned FRAMEERR   = 1;
    localparam int unsigned BUFFULL    = 0;

endpackage

// File: rtl/uart_wait_timer.sv
// Character-waiting-time watchdog: counts enabled, unfrozen cycles up to a
// nonzero limit and holds there; a limit of zero never expires.
module uart_wait_timer #(
    parameter int unsigned TIMEOUT_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     enable,
    input  logic                     freeze,
    input  logic [TIMEOUT_WIDTH-1:0] limit,
    output logic                     expired
);

    logic [TIMEOUT_WIDTH-1:0] count;

    assign expired = (limit != '0) && (count == limit);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !freeze && !expired) begin
            count <= count + TIMEOUT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_exchange_sequencer.sv
// Command-level sequencer for the half-duplex ISO7816 UART: streams a block of
// host bytes out, turns the line around, then collects the response bytes.
module uart_exchange_sequencer
    import uart_seq_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH   = 9,
    parameter int unsigned TIMEOUT_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [COUNT_WIDTH-1:0]   txCount,
    input  logic [COUNT_WIDTH-1:0]   rxCount,
    input  logic [TIMEOUT_WIDTH-1:0] waitCycles,
    input  logic [7:0]               txByte,
    input  logic                     txValid,
    output logic                     txReady,
    output logic [7:0]               rxByte,
    output logic                     rxValid,
    input  logic                     rxReady,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               errorCode,
    output logic [7:0]               uartDataIn,
    output logic                     uartNWeDataIn,
    input  logic [7:0]               uartDataOut,
    output logic                     uartNCsDataOut,
    input  logic [7:0]               uartStatus
);

    seqState_t state, nextState;

    logic [COUNT_WIDTH-1:0]   txRemain, rxRemain;
    logic [TIMEOUT_WIDTH-1:0] waitLimit;
    logic                     csPulse, loadCmd, takeTx, txDec, rxDec, errSet;
    logic [1:0]               errNext;
    logic                     timerClear, timerEnable, timerFreeze, timerExpired;

    // Timer restarts on every state change and only runs while waiting on the line
    assign timerClear  = (nextState != state);
    assign timerEnable = (state == TX_WAIT_SET) || (state == RX_WAIT);
    assign timerFreeze = uartStatus[RXSTARTBIT] || uartStatus[RXRUN];

    uart_wait_timer #(
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
    ) waitTimer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timerClear),
        .enable (timerEnable),
        .freeze (timerFreeze),
        .limit  (waitLimit),
        .expired(timerExpired)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        csPulse   = 1'b0;
        loadCmd   = 1'b0;
        takeTx    = 1'b0;
        txDec     = 1'b0;
        rxDec     = 1'b0;
        errSet    = 1'b0;
        errNext   = ERR_NONE;
        case (state)
            IDLE: begin
                if (start) begin
                    loadCmd = 1'b1;
                    // A stale received byte must be discarded before the line is driven
                    if (uartStatus[BUFFULL] && !uartStatus[TXPENDING]) begin
                        csPulse   = 1'b1;
                        nextState = FLUSH;
                    end else if (txCount == '0) begin
                        nextState = TX_DRAIN;
                    end else begin
                        nextState = TX_LOAD;
                    end
                end
            end
            FLUSH: begin
                if (!uartStatus[BUFFULL]) nextState = (txRemain == '0) ? TX_DRAIN : TX_LOAD;
            end
            TX_LOAD: begin
                if (txValid) begin
                    takeTx    = 1'b1;
                    nextState = TX_WRITE;
                end
            end
            TX_WRITE: nextState = TX_WAIT_SET;
            TX_WAIT_SET: begin
                if (uartStatus[TXPENDING]) begin
                    nextState = TX_WAIT_CLR;
                end else if (timerExpired) begin
                    errSet    = 1'b1;
                    errNext   = ERR_TIMEOUT;
                    nextState = DONE;
                end
            end
            TX_WAIT_CLR: begin
                if (!uartStatus[TXPENDING]) begin
                    txDec     = 1'b1;
                    nextState = (txRemain > COUNT_WIDTH'(1)) ? TX_LOAD : TX_DRAIN;
                end
            end
            TX_DRAIN: begin
                if (!uartStatus[TXRUN] && !uartStatus[TXPENDING]) begin
                    nextState = (rxRemain != '0) ? RX_WAIT : DONE;
                end
            end
            RX_WAIT: begin
                if (uartStatus[BUFFULL] && !uartStatus[ISTX]) begin
                    if (uartStatus[OVERRUN] || uartStatus[FRAMEERR]) begin
                        errSet    = 1'b1;
                        errNext   = uartStatus[OVERRUN] ? ERR_OVERRUN : ERR_FRAME;
                        csPulse   = 1'b1;
                        nextState = DONE;
                    end else begin
                        nextState = RX_HOLD;
                    end
                end else if (timerExpired) begin
                    errSet    = 1'b1;
                    errNext   = ERR_TIMEOUT;
                    nextState = DONE;
                end
            end
            RX_HOLD: begin
                if (rxReady) begin
                    csPulse   = 1'b1;
                    nextState = RX_ACK;
                end
            end
            RX_ACK: begin
                if (!uartStatus[BUFFULL]) begin
                    rxDec     = 1'b1;
                    nextState = (rxRemain > COUNT_WIDTH'(1)) ? RX_WAIT : DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            txRemain       <= '0;
            rxRemain       <= '0;
            waitLimit      <= '0;
            errorCode      <= ERR_NONE;
            uartDataIn     <= 8'h00;
            uartNWeDataIn  <= 1'b1;
            uartNCsDataOut <= 1'b1;
            rxByte         <= 8'h00;
            txReady        <= 1'b0;
            rxValid        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            txReady        <= (nextState == TX_LOAD);
            rxValid        <= (nextState == RX_HOLD);
            busy           <= (nextState != IDLE) && (nextState != DONE);
            done           <= (nextState == DONE);
            uartNWeDataIn  <= (nextState != TX_WRITE);
            uartNCsDataOut <= !csPulse;
            if (takeTx) uartDataIn <= txByte;
            if ((nextState == RX_HOLD) && (state != RX_HOLD)) rxByte <= uartDataOut;
            if (loadCmd) begin
                txRemain  <= txCount;
                rxRemain  <= rxCount;
                waitLimit <= waitCycles;
                errorCode <= ERR_NONE;
            end else begin
                if (txDec && (txRemain != '0)) txRemain <= txRemain - COUNT_WIDTH'(1);
                if (rxDec && (rxRemain != '0)) rxRemain <= rxRemain - COUNT_WIDTH'(1);
                if (errSet) errorCode <= errNext;
            end
        end
    end

endmodule

// File: tb/tb_uart_exchange_sequencer.sv
// Directed bench for uart_exchange_sequencer with a small behavioural model of
// the ISO7816 UART interface byte/status port.
module tb_uart_exchange_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  txCount = 9'd0;
    logic [8:0]  rxCount = 9'd0;
    logic [23:0] waitCycles = 24'd0;
    logic [7:0]  txByte = 8'h00;
    logic        txValid = 1'b0;
    logic        txReady;
    logic [7:0]  rxByte;
    logic        rxValid;
    logic        rxReady = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  errorCode;
    logic [7:0]  uartDataIn;
    logic        uartNWeDataIn;
    logic [7:0]  uartDataOut;
    logic        uartNCsDataOut;
    logic [7:0]  uartStatus;

    int vectors = 0;
    int miscompares = 0;

    uart_exchange_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .txCount       (txCount),
        .rxCount       (rxCount),
        .waitCycles    (waitCycles),
        .txByte        (txByte),
        .txValid       (txValid),
        .txReady       (txReady),
        .rxByte        (rxByte),
        .rxValid       (rxValid),
        .rxReady       (rxReady),
        .busy          (busy),
        .done          (done),
        .errorCode     (errorCode),
        .uartDataIn    (uartDataIn),
        .uartNWeDataIn (uartNWeDataIn),
        .uartDataOut   (uartDataOut),
        .uartNCsDataOut(uartNCsDataOut),
        .uartStatus    (uartStatus)
    );

    always #5 clk = ~clk;

    // UART interface model: a write shows txPending for 3 cycles then txRun for 4;
    // queued response bytes land in the buffer once the transmitter is idle.
    logic [2:0] pendCnt = 3'd0, runCnt = 3'd0, rxGap = 3'd0;
    logic       bufFull = 1'b0, frameErrR = 1'b0, overrunR = 1'b0;
    logic       prevWe = 1'b1, prevCs = 1'b1;
    logic [7:0] dataReg = 8'h00;
    logic [7:0] rxMem [0:7];
    logic [1:0] rxErr [0:7];
    logic [1:0] evKind [0:63];
    logic [7:0] evData [0:63];
    int rxWr = 0, rxRd = 0, evCount = 0, wrCount = 0, rdCount = 0, strobeLong = 0;

    assign uartDataOut = dataReg;
    assign uartStatus  = {runCnt != 3'd0, pendCnt != 3'd0, 1'b0, 1'b0,
                          (pendCnt != 3'd0) || (runCnt != 3'd0), overrunR, frameErrR, bufFull};

    always @(posedge clk) begin
        prevWe <= uartNWeDataIn;
        prevCs <= uartNCsDataOut;
        if ((!uartNWeDataIn && !prevWe) || (!uartNCsDataOut && !prevCs)) strobeLong <= strobeLong + 1;
        if (!uartNWeDataIn) begin
            evKind[6'(evCount)] <= 2'd1;
            evData[6'(evCount)] <= uartDataIn;
            evCount <= evCount + 1;
            wrCount <= wrCount + 1;
        end else if (!uartNCsDataOut) begin
            evKind[6'(evCount)] <= 2'd2;
            evData[6'(evCount)] <= 8'h00;
            evCount <= evCount + 1;
        end
        if (!uartNCsDataOut) rdCount <= rdCount + 1;
        if (reset) begin
            pendCnt <= 3'd0; runCnt <= 3'd0; rxGap <= 3'd0;
            bufFull <= 1'b0; frameErrR <= 1'b0; overrunR <= 1'b0;
            rxRd <= rxWr;
        end else begin
            if (!uartNWeDataIn) begin
                pendCnt <= 3'd3;
            end else if (pendCnt != 3'd0) begin
                pendCnt <= pendCnt - 3'd1;
                if (pendCnt == 3'd1) runCnt <= 3'd4;
            end else if (runCnt != 3'd0) begin
                runCnt <= runCnt - 3'd1;
            end
            if (!uartNCsDataOut) begin
                bufFull <= 1'b0; frameErrR <= 1'b0; overrunR <= 1'b0;
                rxGap <= 3'd3;
            end else if (rxGap != 3'd0) begin
                rxGap <= rxGap - 3'd1;
            end else if (!bufFull && pendCnt == 3'd0 && runCnt == 3'd0 && rxRd != rxWr) begin
                dataReg   <= rxMem[3'(rxRd)];
                frameErrR <= rxErr[3'(rxRd)][0];
                overrunR  <= rxErr[3'(rxRd)][1];
                bufFull   <= 1'b1;
                rxRd      <= rxRd + 1;
            end
        end
    end

    // Results gathered by run_command for the test tasks to judge
    logic [7:0] txBuf [0:7];
    logic [7:0] gotRx [0:7];
    int         gotRxN, cycles, rxValidCycles;
    logic       doneSeen, doneBusy, doneTxRun, busyFirst;
    logic [1:0] doneErr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_command(input logic [8:0] ntx, input logic [8:0] nrx, input logic [23:0] wt,
                               input int nresp, input int readyDelay, input int pokeAt);
        int ti, holdCnt, wr0;
        logic hsTx, hsRx, released;
        ti = 0; holdCnt = 0; gotRxN = 0; cycles = 0; rxValidCycles = 0;
        doneSeen = 1'b0; doneBusy = 1'b0; doneTxRun = 1'b0; doneErr = 2'd0; busyFirst = 1'b0;
        released = (nresp == 0);
        wr0 = wrCount;
        txCount = ntx; rxCount = nrx; waitCycles = wt; start = 1'b1;
        txValid = (ntx != 9'd0); txByte = txBuf[0];
        while (!doneSeen && cycles < 400) begin
            hsTx = txReady && txValid;
            hsRx = rxValid && rxReady;
            if (hsRx && gotRxN < 8) begin
                gotRx[3'(gotRxN)] = rxByte;
                gotRxN++;
            end
            tick();
            cycles++;
            if (cycles == 1) busyFirst = busy;
            start = (cycles == pokeAt);
            if (hsTx) begin
                ti++;
                if (ti < int'(ntx)) txByte = txBuf[3'(ti)];
                else txValid = 1'b0;
            end
            // The card answers only after the last command byte has left the line
            if (!released && (wrCount - wr0 == int'(ntx)) && uartStatus[7:6] == 2'b00) begin
                rxWr = rxWr + nresp;
                released = 1'b1;
            end
            if (rxValid) begin rxValidCycles++; holdCnt++; end
            else holdCnt = 0;
            rxReady = rxValid && (holdCnt > readyDelay);
            if (done) begin
                doneSeen = 1'b1; doneErr = errorCode; doneBusy = busy; doneTxRun = uartStatus[7];
            end
        end
        txValid = 1'b0; rxReady = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (txReady !== 1'b0 || rxValid !== 1'b0) begin miscompares++; $display("FAIL reset_handshake: got txReady=%b rxValid=%b expected 0 0", txReady, rxValid); end
        vectors++; if (errorCode !== 2'd0) begin miscompares++; $display("FAIL reset_error: got %0d expected 0", errorCode); end
        vectors++; if (uartNWeDataIn !== 1'b1 || uartNCsDataOut !== 1'b1) begin miscompares++; $display("FAIL reset_strobes: got we=%b cs=%b expected 1 1", uartNWeDataIn, uartNCsDataOut); end
        vectors++; if (uartDataIn !== 8'h00) begin miscompares++; $display("FAIL reset_datain: got %h expected 00", uartDataIn); end
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_transmit_only();
        int ev0;
        ev0 = evCount;
        txBuf[0] = 8'h3B; txBuf[1] = 8'h9A;
        run_command(9'd2, 9'd0, 24'd0, 0, 0, 0);
        tick();
        vectors++; if (busyFirst !== 1'b1) begin miscompares++; $display("FAIL tx_busy_rise: got %b expected 1", busyFirst); end
        vectors++; if (doneSeen !== 1'b1) begin miscompares++; $display("FAIL tx_done: got %b expected 1", doneSeen); end
        vectors++; if (evCount - ev0 !== 2) begin miscompares++; $display("FAIL tx_strobes: got %0d expected 2", evCount - ev0); end
        vectors++; if (evKind[6'(ev0)] !== 2'd1 || evData[6'(ev0)] !== 8'h3B) begin miscompares++; $display("FAIL tx_byte0: got kind %0d data %h expected 1 3b", evKind[6'(ev0)], evData[6'(ev0)]); end
        vectors++; if (evKind[6'(ev0 + 1)] !== 2'd1 || evData[6'(ev0 + 1)] !== 8'h9A) begin miscompares++; $display("FAIL tx_byte1: got kind %0d data %h expected 1 9a", evKind[6'(ev0 + 1)], evData[6'(ev0 + 1)]); end
        vectors++; if (doneTxRun !== 1'b0 || doneBusy !== 1'b0) begin miscompares++; $display("FAIL tx_done_timing: got txRun=%b busy=%b expected 0 0", doneTxRun, doneBusy); end
        vectors++; if (doneErr !== 2'd0) begin miscompares++; $display("FAIL tx_error: got %0d expected 0", doneErr); end
    endtask

    task automatic test_exchange();
        int rd0, wr0;
        rd0 = rdCount; wr0 = wrCount;
        txBuf[0] = 8'hC0;
        rxMem[3'(rxWr)] = 8'h90;     rxErr[3'(rxWr)] = 2'b00;
        rxMem[3'(rxWr + 1)] = 8'h00; rxErr[3'(rxWr + 1)] = 2'b00;
        // Host holds off rxReady longer than the watchdog limit: must not time out
        run_command(9'd1, 9'd2, 24'd20, 2, 30, 0);
        tick();
        vectors++; if (doneSeen !== 1'b1 || doneErr !== 2'd0) begin miscompares++; $display("FAIL xchg_done: got done=%b err=%0d expected 1 0", doneSeen, doneErr); end
        vectors++; if (gotRxN !== 2) begin miscompares++; $display("FAIL xchg_count: got %0d expected 2", gotRxN); end
        vectors++; if (gotRx[0] !== 8'h90) begin miscompares++; $display("FAIL xchg_byte0: got %h expected 90", gotRx[0]); end
        vectors++; if (gotRx[1] !== 8'h00) begin miscompares++; $display("FAIL xchg_byte1: got %h expected 00", gotRx[1]); end
        vectors++; if (rdCount - rd0 !== 2) begin miscompares++; $display("FAIL xchg_reads: got %0d expected 2", rdCount - rd0); end
        vectors++; if (wrCount - wr0 !== 1) begin miscompares++; $display("FAIL xchg_writes: got %0d expected 1", wrCount - wr0); end
    endtask

    task automatic test_timeout();
        int rd0;
        rd0 = rdCount;
        // 2 cycles to reach RX_WAIT, counter runs 0..100, then one cycle into DONE
        run_command(9'd0, 9'd1, 24'd100, 0, 0, 0);
        tick();
        vectors++; if (doneSeen !== 1'b1 || cycles !== 103) begin miscompares++; $display("FAIL tmo_cycle: got done=%b at %0d expected 1 at 103", doneSeen, cycles); end
        vectors++; if (doneErr !== 2'd1) begin miscompares++; $display("FAIL tmo_error: got %0d expected 1", doneErr); end
        vectors++; if (rdCount - rd0 !== 0) begin miscompares++; $display("FAIL tmo_reads: got %0d expected 0", rdCount - rd0); end
    endtask

    task automatic test_rx_errors();
        int rd0;
        rd0 = rdCount;
        txBuf[0] = 8'hA4;
        rxMem[3'(rxWr)] = 8'h6C; rxErr[3'(rxWr)] = 2'b01;
        run_command(9'd1, 9'd1, 24'd0, 1, 0, 0);
        tick();
        vectors++; if (doneErr !== 2'd2) begin miscompares++; $display("FAIL frame_error: got %0d expected 2", doneErr); end
        vectors++; if (rxValidCycles !== 0) begin miscompares++; $display("FAIL frame_rxvalid: got %0d cycles expected 0", rxValidCycles); end
        vectors++; if (rdCount - rd0 !== 1) begin miscompares++; $display("FAIL frame_reads: got %0d expected 1", rdCount - rd0); end
        repeat (4) tick();
        rd0 = rdCount;
        rxMem[3'(rxWr)] = 8'h6C; rxErr[3'(rxWr)] = 2'b11;
        run_command(9'd1, 9'd1, 24'd0, 1, 0, 0);
        tick();
        vectors++; if (doneErr !== 2'd3) begin miscompares++; $display("FAIL overrun_error: got %0d expected 3", doneErr); end
        vectors++; if (rdCount - rd0 !== 1) begin miscompares++; $display("FAIL overrun_reads: got %0d expected 1", rdCount - rd0); end
    endtask

    task automatic test_flush_and_ignored_start();
        int ev0, wr0;
        rxMem[3'(rxWr)] = 8'h55; rxErr[3'(rxWr)] = 2'b00;
        rxWr = rxWr + 1;
        repeat (6) tick();
        ev0 = evCount; wr0 = wrCount;
        txBuf[0] = 8'h11; txBuf[1] = 8'h22;
        run_command(9'd2, 9'd0, 24'd0, 0, 0, 5);
        repeat (5) tick();
        vectors++; if (evKind[6'(ev0)] !== 2'd2) begin miscompares++; $display("FAIL flush_first: got kind %0d expected 2", evKind[6'(ev0)]); end
        vectors++; if (evKind[6'(ev0 + 1)] !== 2'd1 || evData[6'(ev0 + 1)] !== 8'h11) begin miscompares++; $display("FAIL flush_write0: got kind %0d data %h expected 1 11", evKind[6'(ev0 + 1)], evData[6'(ev0 + 1)]); end
        vectors++; if (wrCount - wr0 !== 2) begin miscompares++; $display("FAIL poke_writes: got %0d expected 2", wrCount - wr0); end
        vectors++; if (busy !== 1'b0 || doneSeen !== 1'b1) begin miscompares++; $display("FAIL poke_idle: got busy=%b done=%b expected 0 1", busy, doneSeen); end
        vectors++; if (strobeLong !== 0) begin miscompares++; $display("FAIL strobe_width: got %0d long pulses expected 0", strobeLong); end
    endtask

    task automatic test_reset_mid_command();
        int n;
        logic sawDone;
        rxMem[3'(rxWr)] = 8'h6A; rxErr[3'(rxWr)] = 2'b00;
        txCount = 9'd0; rxCount = 9'd1; waitCycles = 24'd0; start = 1'b1;
        tick();
        start = 1'b0;
        rxWr = rxWr + 1;
        n = 0;
        while (!rxValid && n < 50) begin tick(); n++; end
        vectors++; if (rxValid !== 1'b1 || rxByte !== 8'h6A) begin miscompares++; $display("FAIL hold_reached: got rxValid=%b byte=%h expected 1 6a", rxValid, rxByte); end
        reset = 1'b1;
        tick();
        vectors++; if (busy !== 1'b0 || rxValid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_state: got busy=%b rxValid=%b expected 0 0", busy, rxValid); end
        vectors++; if (uartNWeDataIn !== 1'b1 || uartNCsDataOut !== 1'b1) begin miscompares++; $display("FAIL rst_mid_strobes: got we=%b cs=%b expected 1 1", uartNWeDataIn, uartNCsDataOut); end
        sawDone = done;
        reset = 1'b0;
        repeat (6) begin tick(); sawDone = sawDone | done; end
        vectors++; if (sawDone !== 1'b0) begin miscompares++; $display("FAIL rst_mid_done: got %b expected 0", sawDone); end
    endtask

    initial begin
        test_reset();
        test_transmit_only();
        test_exchange();
        test_timeout();
        test_rx_errors();
        test_flush_and_ignored_start();
        test_reset_mid_command();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_exchange_sequencer.md
# uart_exchange_sequencer

Command-level controller for the half-duplex ISO7816 UART interface: on one `start` it transmits `txCount` bytes streamed from the host, waits for the line to turn around, then collects `rxCount` response bytes. Runs a character-waiting-time watchdog and reports completion and error status. Sits between the protocol layer (T=0 / APDU logic) and the UART interface's byte/status port; the UART interface is its only client.

## Interface
- `COUNT_WIDTH`, 9: width of byte counters (up to 511 bytes per direction).
- `TIMEOUT_WIDTH`, 24: width of the waiting-time counter, in `clk` cycles.

- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  1-cycle command pulse; honoured only when `busy`=0.
- `txCount`  in  COUNT_WIDTH  bytes to send; latched on `start`.
- `rxCount`  in  COUNT_WIDTH  bytes to receive; latched on `start`.
- `waitCycles`  in  TIMEOUT_WIDTH  watchdog limit; latched on `start`; 0 disables the watchdog.
- `txByte`  in  8  host transmit byte.
- `txValid`  in  1  `txByte` valid.
- `txReady`  out  1  byte taken when `txValid`&`txReady`.
- `rxByte`  out  8  received byte.
- `rxValid`  out  1  `rxByte` valid; held until accepted.
- `rxReady`  in  1  host accepts `rxByte`.
- `busy`  out  1  command in progress.
- `done`  out  1  1-cycle pulse at command end.
- `errorCode`  out  2  0 none, 1 timeout, 2 frame/parity, 3 overrun; valid with `done`, held until next `start`.
- `uartDataIn`  out  8  byte to the UART interface.
- `uartNWeDataIn`  out  1  active-low write strobe.
- `uartDataOut`  in  8  UART interface data register.
- `uartNCsDataOut`  out  1  active-low read strobe; clears the buffer.
- `uartStatus`  in  8  {txRun, txPending, rxRun, rxStartBit, isTx, overrun, frameErr, bufferFull} (bit 7 first).

## Operation
- States: IDLE, FLUSH, TX_LOAD, TX_WRITE, TX_WAIT_SET, TX_WAIT_CLR, TX_DRAIN, RX_WAIT, RX_HOLD, RX_ACK, DONE.
- IDLE + `start`: latch counts/limit, clear `errorCode`. If bufferFull=1 and txPending=0, go FLUSH: one `uartNCsDataOut` pulse, then wait for bufferFull=0. Otherwise go to TX_LOAD, or to TX_DRAIN if `txCount`=0.
- TX_LOAD: `txReady`=1. On handshake, register the byte into `uartDataIn` and go to TX_WRITE.
- TX_WRITE: `uartNWeDataIn`=0 for exactly one cycle, then go to TX_WAIT_SET.
- TX_WAIT_SET: wait for txPending=1. TX_WAIT_CLR: wait for txPending=0. Then decrement the remaining count: go to TX_LOAD if it is nonzero, else to TX_DRAIN.
- TX_DRAIN: wait for txRun=0 and txPending=0. Then go to RX_WAIT, or to DONE if `rxCount`=0.
- RX_WAIT: on bufferFull=1 with isTx=0:
  - overrun → error 3;
  - else frameErr → error 2;
  - in both error cases, pulse `uartNCsDataOut` once and go to DONE;
  - else go to RX_HOLD.
- RX_HOLD: `rxByte`=`uartDataOut`, `rxValid`=1. On `rxReady`, pulse `uartNCsDataOut` once and go to RX_ACK.
- RX_ACK: wait for bufferFull=0, decrement the count, then go to RX_WAIT or DONE.
- Watchdog:
  - Counts in TX_WAIT_SET and RX_WAIT.
  - Reloads to 0 on every state entry.
  - Frozen while rxStartBit or rxRun is set.
  - Reaching `waitCycles` (nonzero) → error 1, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while `busy` is ignored. Host stalls (`txValid`=0, `rxReady`=0) never time out.

## Timing
- Reset values: `txReady`=0, `rxValid`=0, `busy`=0, `done`=0, `errorCode`=0, `uartNWeDataIn`=1, `uartNCsDataOut`=1, `uartDataIn`=0, state IDLE.
- Reset mid-command: abandon the command with no `done` pulse. Strobes deassert on the first reset cycle.
- All UART strobes and `uartDataIn` are registered; each strobe pulse is exactly one cycle.
- `busy` rises the cycle after `start`. It falls in the same cycle `done` is high.
- `txReady` and `rxValid` are decoded from the registered state only.
- Counters are COUNT_WIDTH unsigned and never wrap: decrement only happens when the value is nonzero.
- The watchdog comparison is `counter == waitCycles`; it saturates there.

## Structure
- Shared package `uart_seq_pkg`: state encoding, errorCode constants, uartStatus bit indices (TXRUN=7 … BUFFULL=0).
- One sub-module, `uart_wait_timer`: clear/enable/freeze inputs, limit input, `expired` output.

## Test plan
- txCount=2 (0x3B, 0x9A), rxCount=0, waitCycles=0 → two single-cycle write strobes with matching `uartDataIn`; `done` only after txRun=0; errorCode=0.
- txCount=1, rxCount=2, model returns 0x90, 0x00 → `rxByte` 0x90 then 0x00; one read strobe per `rxReady`; `done` with errorCode=0.
- rxCount=1, waitCycles=100, no reply → `done` on the 100th RX_WAIT cycle with errorCode=1; no read strobe.
- Response byte arrives with frameErr=1 → one read strobe, `rxValid` never asserted, errorCode=2.
- bufferFull=1 at `start` → FLUSH read strobe precedes the first write. `start` pulsed mid-command is ignored.
- `reset` asserted in RX_HOLD → next cycle `busy`=0, `rxValid`=0, strobes high, no `done`.
